// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, async ROM address.
// Optional stall/flush performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          DELAY_SLOT = 1,
   parameter logic [31:0] NOP_INST   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_pc,
   output logic [31:0] id_pc4,
   output logic [31:0] id_inst,
   output logic        id_valid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   localparam logic SQUASH = (DELAY_SLOT == 0);

   logic [31:0] pc_q, pc_d;
   logic [31:0] id_pc4_q, id_pc4_d;
   logic [31:0] id_inst_q, id_inst_d;
   logic        id_valid_q, id_valid_d;
   logic [31:0] pc_plus4;
   logic [31:0] target;
   logic        redirect;

   assign pc_plus4 = pc_q + 32'd4;
   // A stalled ID stage has not resolved its branch yet, so redirects wait.
   assign redirect = (jump | branch_taken) & ~stall;
   assign target   = jump ? {jump_target[31:2], 2'b00} : {branch_target[31:2], 2'b00};

   always_comb begin
      pc_d       = pc_q;
      id_pc4_d   = id_pc4_q;
      id_inst_d  = id_inst_q;
      id_valid_d = id_valid_q;
      if (!stall) begin
         pc_d     = redirect ? target : pc_plus4;
         id_pc4_d = pc_plus4;
         if (redirect && SQUASH) begin
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
         end else begin
            id_inst_d  = imem_rdata;
            id_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         id_pc4_q   <= 32'd0;
         id_inst_q  <= NOP_INST;
         id_valid_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         id_pc4_q   <= id_pc4_d;
         id_inst_q  <= id_inst_d;
         id_valid_q <= id_valid_d;
      end
   end

   assign imem_addr = pc_q;
   assign if_pc     = pc_q;
   assign id_pc4    = id_pc4_q;
   assign id_inst   = id_inst_q;
   assign id_valid  = id_valid_q;

`ifdef IF_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q + {31'd0, stall};
      flush_cnt_d = flush_cnt_q + {31'd0, (redirect & SQUASH)};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and the IF/ID pipeline register, and drives the asynchronous instruction ROM.
- Consumes `stall` from the ID-stage forward/stall controller and the branch/jump redirect resolved in ID.
- Feeds `id_pc4`/`id_inst`/`id_valid` into the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DELAY_SLOT, 1, 1 = instruction fetched in the redirect cycle is kept (MIPS delay slot); 0 = it is squashed to a bubble.
- NOP_INST, 32'h0000_0000, encoding written into `id_inst` for a bubble.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- stall  input  1  hold request from the ID forward/stall controller
- branch_taken  input  1  conditional branch resolved taken in ID
- branch_target  input  32  branch destination
- jump  input  1  J/JAL/JR resolved in ID
- jump_target  input  32  jump destination
- imem_addr  output  32  instruction ROM address (combinational = pc)
- imem_rdata  input  32  ROM data, same-cycle asynchronous read
- if_pc  output  32  current fetch PC
- id_pc4  output  32  registered PC+4 of the ID instruction
- id_inst  output  32  registered instruction in ID
- id_valid  output  1  1 = `id_inst` is real, 0 = bubble

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - pc <= RESET_PC
  - id_pc4 <= 0
  - id_inst <= NOP_INST
  - id_valid <= 0
  - `rst` overrides every other input, including mid-stall and mid-redirect.
  - Counters under the optional feature clear to 0.
- Combinational outputs: `imem_addr = pc` and `if_pc = pc`. No fetch latency beyond the ROM's combinational path.
- Redirect decode:
  - `redirect = (jump | branch_taken) & ~stall`.
  - When both `jump` and `branch_taken` are set, `jump` wins: `target = jump ? jump_target : branch_target`.
  - `target[1:0]` is forced to 2'b00.
- Per-cycle update, priority high to low:
  1. `stall=1`: pc and all IF/ID registers hold their values. Any redirect input in the same cycle is ignored, because ID has not resolved it yet and the ID stage re-presents it after the stall.
  2. `redirect=1`: pc <= target.
     - DELAY_SLOT=1: id_pc4 <= pc+4, id_inst <= imem_rdata, id_valid <= 1.
     - DELAY_SLOT=0: id_pc4 <= pc+4, id_inst <= NOP_INST, id_valid <= 0.
  3. Otherwise: pc <= pc+4, id_pc4 <= pc+4, id_inst <= imem_rdata, id_valid <= 1.
- Arithmetic: pc+4 is 32-bit modulo. 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- Latency: an instruction at address A appears on `id_inst` one cycle after pc=A, plus one cycle per stall cycle.
- Back-to-back redirects: each one is handled independently. There is no state machine beyond the pc and IF/ID registers.

Optional Feature:
- Macro: IF_PERF_CNT_EN
- Defined:
  - Adds outputs `stall_cnt` [31:0] and `flush_cnt` [31:0].
  - `stall_cnt` increments on every cycle with stall=1 and rst=0.
  - `flush_cnt` increments on every redirect cycle where DELAY_SLOT=0.
  - Both counters wrap modulo 2^32 and clear on rst.
- Undefined: the ports and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset then run: rst=1 for 2 cycles, release, ROM[i]=i+1 -> if_pc = 0,4,8 on successive cycles; id_inst = 1,2,3 delayed one cycle; id_valid=0 during reset, 1 after.
- Stall hold: pc=0x10, stall=1 for 3 cycles -> pc stays 0x10; id_inst/id_pc4 unchanged; on release next pc=0x14 and id_inst=ROM[0x10>>2].
- Branch with delay slot: DELAY_SLOT=1, pc=0x20, branch_taken=1, branch_target=0x103 -> pc=0x100 next cycle; id_inst=ROM[0x20>>2], id_valid=1.
- Branch squash: DELAY_SLOT=0, same stimulus -> id_inst=NOP_INST, id_valid=0, pc=0x100; flush_cnt +1 when IF_PERF_CNT_EN is defined.
- Simultaneous events:
  - stall=1 & jump=1 -> pc holds; jump ignored.
  - jump=1 & branch_taken=1, jump_target=0x400, branch_target=0x800 -> pc=0x400.
- Wrap and reset mid-operation: pc=0xFFFF_FFFC, no stall -> pc=0x0; assert rst with stall=1 -> pc=RESET_PC and id_valid=0 in one cycle.
